// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: Y86-64 pipeline stall/bubble control, condition codes,
// exception/halt state machine and saturating hazard counters.
module pipe_hazard_ctrl #(
  parameter int         CNT_W    = 32,
  parameter logic [3:0] STAT_AOK = 4'h1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [3:0]       E_dstM,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  input  logic [2:0]       alu_cc,
  output logic             e_cnd,
  output logic             set_cc,
  output logic [2:0]       cc,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             halted,
  output logic [3:0]       halt_code,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;
  state_e state_q, state_d;
  logic [2:0] cc_q, cc_d;
  logic [3:0] halt_code_q, halt_code_d, m_stat_v, w_stat_v;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, mispred_cnt_q, mispred_cnt_d;
  logic load_use, ret_pend, mispred, exc, m_bad, w_bad, cond, run, drain, hlt, lt;
  // Stat inputs read as AOK while reset is held so the controls settle to reset values
  assign m_stat_v = rst_n ? m_stat : STAT_AOK;
  assign w_stat_v = rst_n ? W_stat : STAT_AOK;
  always_comb begin
    run = state_q == RUN;
    drain = state_q == DRAIN;
    hlt = state_q == HALTED;
    load_use = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
               (E_dstM == d_srcA || E_dstM == d_srcB);
    ret_pend = D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
    m_bad = m_stat_v != STAT_AOK;
    w_bad = w_stat_v != STAT_AOK;
    exc = m_bad | w_bad;
    lt = cc_q[1] ^ cc_q[2];
    cond = 1'b0;
    case (E_ifun)
      4'h0: cond = 1'b1;
      4'h1: cond = lt | cc_q[0];
      4'h2: cond = lt;
      4'h3: cond = cc_q[0];
      4'h4: cond = ~cc_q[0];
      4'h5: cond = ~lt;
      4'h6: cond = ~lt & ~cc_q[0];
      default: cond = 1'b0;
    endcase
    e_cnd = (E_icode == 4'h2 || E_icode == 4'h7) & cond;
    mispred = E_icode == 4'h7 && !e_cnd;
    F_stall = hlt | load_use | ret_pend;
    D_stall = hlt | load_use;
    D_bubble = ~hlt & (mispred | (ret_pend & ~load_use));
    E_bubble = hlt | mispred | load_use;
    M_bubble = hlt | drain | exc;
    W_stall = hlt | w_bad;
    set_cc = run & (E_icode == 4'h6) & ~exc;
    cc_d = set_cc ? alu_cc : cc_q;
    state_d = (!hlt && w_bad) ? HALTED : (run && m_bad) ? DRAIN : state_q;
    halt_code_d = (!hlt && w_bad) ? w_stat_v : halt_code_q;
    stall_cnt_d = (run && (load_use || ret_pend) && !(&stall_cnt_q)) ?
                  stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    mispred_cnt_d = (run && mispred && !(&mispred_cnt_q)) ?
                    mispred_cnt_q + CNT_W'(1) : mispred_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cc_q <= 3'b001;
      halt_code_q <= 4'h0;
      stall_cnt_q <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cc_q <= cc_d;
      halt_code_q <= halt_code_d;
      stall_cnt_q <= stall_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end
  assign cc = cc_q;
  assign halted = state_q == HALTED;
  assign halt_code = halt_code_q;
  assign stall_cnt = stall_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plan plus randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int SAT = 15;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_ifun, E_dstM, M_icode, m_stat, W_stat;
  logic [2:0] alu_cc, cc;
  logic e_cnd, set_cc, F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, halted;
  logic [3:0] halt_code;
  logic [CNT_W-1:0] stall_cnt, mispred_cnt;
  int checks = 0, failures = 0;
  int mode, n_mode, mst, n_mst, mmp, n_mmp, hcnt;
  logic [2:0] mcc, n_mcc;
  logic [3:0] mhc, n_mhc;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .STAT_AOK(4'h1)) dut (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_dstM(E_dstM), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .alu_cc(alu_cc), .e_cnd(e_cnd), .set_cc(set_cc),
    .cc(cc), .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .halted(halted),
    .halt_code(halt_code), .stall_cnt(stall_cnt), .mispred_cnt(mispred_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic idle();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; E_ifun = 4'h0;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
    m_stat = 4'h1; W_stat = 4'h1; alu_cc = 3'b000;
  endtask

  function automatic logic cond_of(input logic [3:0] f, input logic [2:0] c);
    logic zf, sf, of, l;
    zf = c[0]; sf = c[1]; of = c[2]; l = sf ^ of;
    case (f)
      4'h0: return 1'b1;
      4'h1: return l | zf;
      4'h2: return l;
      4'h3: return zf;
      4'h4: return !zf;
      4'h5: return !l;
      4'h6: return !l && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic at_neg();
    logic lu, rp, cn, mp, ex, mb, wb, h, dr, scc;
    logic [3:0] ms, ws;
    @(negedge clk);
    if (!rst_n) begin mode = 0; mcc = 3'b001; mhc = 4'h0; mst = 0; mmp = 0; end
    ms = rst_n ? m_stat : 4'h1;
    ws = rst_n ? W_stat : 4'h1;
    lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF && (E_dstM == d_srcA || E_dstM == d_srcB);
    rp = D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
    cn = (E_icode == 4'h2 || E_icode == 4'h7) && cond_of(E_ifun, mcc);
    mp = E_icode == 4'h7 && !cn;
    mb = ms != 4'h1; wb = ws != 4'h1; ex = mb || wb;
    h = mode == 2; dr = mode == 1;
    scc = mode == 0 && E_icode == 4'h6 && !ex;
    chk("e_cnd", e_cnd, cn);
    chk("F_stall", F_stall, h || lu || rp);
    chk("D_stall", D_stall, h || lu);
    chk("D_bubble", D_bubble, !h && (mp || (rp && !lu)));
    chk("E_bubble", E_bubble, h || mp || lu);
    chk("M_bubble", M_bubble, h || dr || ex);
    chk("W_stall", W_stall, h || wb);
    chk("set_cc", set_cc, scc);
    chk("cc", cc, mcc);
    chk("halted", halted, h);
    chk("halt_code", halt_code, mhc);
    chk("stall_cnt", stall_cnt, mst);
    chk("mispred_cnt", mispred_cnt, mmp);
    n_mcc = scc ? alu_cc : mcc;
    n_mst = (mode == 0 && (lu || rp) && mst < SAT) ? mst + 1 : mst;
    n_mmp = (mode == 0 && mp && mmp < SAT) ? mmp + 1 : mmp;
    n_mode = mode; n_mhc = mhc;
    if (mode != 2 && wb) begin n_mode = 2; n_mhc = ws; end
    else if (mode == 0 && mb) n_mode = 1;
    if (!rst_n) begin n_mode = 0; n_mcc = 3'b001; n_mhc = 4'h0; n_mst = 0; n_mmp = 0; end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
    mode = n_mode; mcc = n_mcc; mhc = n_mhc; mst = n_mst; mmp = n_mmp;
  endtask

  function automatic logic [3:0] pick_reg();
    return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    idle();
    at_neg();
    chk("rst_halted", halted, 0);
    chk("rst_cc", cc, 3'b001);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_mispred_cnt", mispred_cnt, 0);
    to_pos();
    rst_n = 1'b1;
    // load-use
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    at_neg();
    chk("lu_F_stall", F_stall, 1); chk("lu_D_stall", D_stall, 1);
    chk("lu_E_bubble", E_bubble, 1); chk("lu_D_bubble", D_bubble, 0);
    to_pos();
    E_dstM = 4'hF;
    at_neg();
    chk("lu_cnt", stall_cnt, 1); chk("nolu_F_stall", F_stall, 0); chk("nolu_E_bubble", E_bubble, 0);
    to_pos();
    // flags and branch
    idle(); E_icode = 4'h6; alu_cc = 3'b010;
    at_neg(); chk("opq_set_cc", set_cc, 1); to_pos();
    idle(); E_icode = 4'h7; E_ifun = 4'h2;
    at_neg(); chk("cc_sf", cc, 3'b010); chk("jl_cnd", e_cnd, 1); chk("jl_D_bubble", D_bubble, 0); to_pos();
    E_ifun = 4'h5;
    at_neg(); chk("jge_cnd", e_cnd, 0); chk("jge_D_bubble", D_bubble, 1); chk("jge_E_bubble", E_bubble, 1); to_pos();
    idle();
    at_neg(); chk("mispred_cnt1", mispred_cnt, 1); to_pos();
    // ret through D, E, M
    D_icode = 4'h9;
    at_neg(); chk("retD_F", F_stall, 1); chk("retD_Db", D_bubble, 1); to_pos();
    D_icode = 4'h1; E_icode = 4'h9;
    at_neg(); chk("retE_F", F_stall, 1); chk("retE_Db", D_bubble, 1); to_pos();
    E_icode = 4'h1; M_icode = 4'h9;
    at_neg(); chk("retM_F", F_stall, 1); chk("retM_Db", D_bubble, 1); to_pos();
    M_icode = 4'h1;
    at_neg(); chk("retX_F", F_stall, 0); chk("retX_Db", D_bubble, 0); chk("ret_cnt", stall_cnt, 4); to_pos();
    // exception gating and halt
    E_icode = 4'h6; alu_cc = 3'b111; m_stat = 4'h3;
    at_neg(); chk("exc_set_cc", set_cc, 0); chk("exc_M_bubble", M_bubble, 1); to_pos();
    idle(); W_stat = 4'h3;
    at_neg(); chk("drain_M_bubble", M_bubble, 1); chk("drain_cc", cc, 3'b010); chk("drain_W_stall", W_stall, 1); to_pos();
    idle();
    at_neg(); chk("halt_halted", halted, 1); chk("halt_code", halt_code, 3); chk("halt_W_stall", W_stall, 1); to_pos();
    at_neg(); chk("halt_persist", halted, 1); to_pos();
    // async reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_halted", halted, 0); chk("arst_cc", cc, 3'b001);
    chk("arst_stall_cnt", stall_cnt, 0); chk("arst_mispred_cnt", mispred_cnt, 0);
    at_neg(); to_pos();
    rst_n = 1'b1; E_icode = 4'h2; E_ifun = 4'h3;
    at_neg(); chk("cmove_cnd", e_cnd, 1); to_pos();
    // saturation
    idle(); E_icode = 4'hB; E_dstM = 4'h2; d_srcB = 4'h2;
    for (int i = 0; i < 16; i++) begin at_neg(); to_pos(); end
    at_neg(); chk("sat_cnt", stall_cnt, SAT); to_pos();
    at_neg(); chk("sat_hold", stall_cnt, SAT); to_pos();
    // randomized traffic
    hcnt = 0;
    for (int i = 0; i < 4000; i++) begin
      hcnt = (mode == 2) ? hcnt + 1 : 0;
      if (hcnt > 3 || $urandom_range(0, 299) == 0) begin rst_n = 1'b0; hcnt = 0; end
      else rst_n = 1'b1;
      D_icode = 4'($urandom_range(0, 11)); E_icode = 4'($urandom_range(0, 11));
      M_icode = 4'($urandom_range(0, 11)); E_ifun = 4'($urandom_range(0, 7));
      d_srcA = pick_reg(); d_srcB = pick_reg(); E_dstM = pick_reg();
      m_stat = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
      W_stat = ($urandom_range(0, 59) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
      alu_cc = 3'($urandom_range(0, 7));
      at_neg();
      to_pos();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
